// File: rtl/dmem_pkg.sv
// Shared definitions for the data-memory responder.
// Contents: access-size encodings, FSM state encoding, default parameter values.
package dmem_pkg;

  // Access size encodings (req_size); 2'b11 is reserved and behaves as a word.
  localparam logic [1:0] SIZE_BYTE = 2'b00;
  localparam logic [1:0] SIZE_HALF = 2'b01;
  localparam logic [1:0] SIZE_WORD = 2'b10;
  localparam logic [1:0] SIZE_RSVD = 2'b11;

  typedef enum logic [1:0] {
    StIdle = 2'd0,
    StWait = 2'd1,
    StResp = 2'd2
  } state_e;

  localparam int unsigned DEF_ADDR_W      = 32;
  localparam int unsigned DEF_DATA_W      = 32;
  localparam int unsigned DEF_DEPTH_WORDS = 1024;
  localparam int unsigned DEF_WAIT_CYCLES = 1;

  // Wait counter width; holds WAIT_CYCLES-1 for WAIT_CYCLES up to 15.
  localparam int unsigned CNT_W = 4;

endpackage

// File: rtl/dmem_lane_align.sv
// Combinational byte-lane steering for 32-bit little-endian storage.
// Ports:
//   i_offset  byte offset within the word (addr[1:0])
//   i_size    access size (SIZE_BYTE/HALF/WORD, reserved = word)
//   i_wdata   right-justified store data
//   i_rword   full stored word at the addressed index
//   o_be      per-lane write enable
//   o_wdata   store data replicated onto the addressed lanes
//   o_rdata   right-justified load data, upper bits zero
// Half accesses ignore offset bit 0 and word accesses ignore the whole offset.
module dmem_lane_align
  import dmem_pkg::*;
(
  input  logic [1:0]  i_offset,
  input  logic [1:0]  i_size,
  input  logic [31:0] i_wdata,
  input  logic [31:0] i_rword,
  output logic [3:0]  o_be,
  output logic [31:0] o_wdata,
  output logic [31:0] o_rdata
);

  logic [1:0]  w_lane;
  logic [31:0] w_rshift;

  always_comb begin
    w_lane  = 2'b00;
    o_be    = 4'b1111;
    o_wdata = i_wdata;
    case (i_size)
      SIZE_BYTE: begin
        w_lane  = i_offset;
        o_be    = 4'b0001 << w_lane;
        o_wdata = {4{i_wdata[7:0]}};
      end
      SIZE_HALF: begin
        w_lane  = {i_offset[1], 1'b0};
        o_be    = 4'b0011 << w_lane;
        o_wdata = {2{i_wdata[15:0]}};
      end
      default: begin
        w_lane  = 2'b00;
        o_be    = 4'b1111;
        o_wdata = i_wdata;
      end
    endcase
  end

  // Bring the addressed lane down to bit 0, then mask to the access size.
  assign w_rshift = i_rword >> {w_lane, 3'b000};

  always_comb begin
    case (i_size)
      SIZE_BYTE: o_rdata = {24'b0, w_rshift[7:0]};
      SIZE_HALF: o_rdata = {16'b0, w_rshift[15:0]};
      default:   o_rdata = w_rshift;
    endcase
  end

endmodule

// File: rtl/dmem_responder.sv
// Single-outstanding data-memory responder with fixed request-to-response latency.
// Ports:
//   clk, rst (async, active-low)
//   req_valid/req_ready   request handshake; ready only in IDLE
//   req_addr/req_we/req_size/req_wdata  request fields, sampled on the accept edge
//   rsp_valid/rsp_ready   response handshake
//   rsp_rdata/rsp_err     response payload, held stable until accepted
// Build option: DMEM_MISALIGN_ERR_EN enables misalignment detection (err=1, no write).
module dmem_responder
  import dmem_pkg::*;
#(
  parameter int unsigned ADDR_W      = DEF_ADDR_W,
  parameter int unsigned DATA_W      = DEF_DATA_W,
  parameter int unsigned DEPTH_WORDS = DEF_DEPTH_WORDS,
  parameter int unsigned WAIT_CYCLES = DEF_WAIT_CYCLES
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              req_valid,
  output logic              req_ready,
  input  logic [ADDR_W-1:0] req_addr,
  input  logic              req_we,
  input  logic [1:0]        req_size,
  input  logic [DATA_W-1:0] req_wdata,
  output logic              rsp_valid,
  input  logic              rsp_ready,
  output logic [DATA_W-1:0] rsp_rdata,
  output logic              rsp_err
);

  localparam int unsigned    IDX_W    = $clog2(DEPTH_WORDS);
  localparam logic [CNT_W-1:0] CNT_LOAD = CNT_W'(WAIT_CYCLES - 1);

  state_e           r_state, w_state_next;
  logic [CNT_W-1:0] r_cnt, w_cnt_next;
  logic [IDX_W+1:0] r_addr;
  logic             r_we;
  logic [1:0]       r_size;
  logic [31:0]      r_wdata;
  logic [31:0]      r_rdata, w_rdata_next;
  logic             r_err, w_err_next;
  logic [31:0]      r_mem [DEPTH_WORDS];

  logic             w_accept;
  logic             w_commit;
  logic             w_misaligned;
  logic             w_mem_we;
  logic [3:0]       w_be;
  logic [31:0]      w_wdata_lanes;
  logic [31:0]      w_rword;
  logic [31:0]      w_rdata_rj;
  logic             w_unused_addr;

  // Address bits above the word index are deliberately ignored (aliasing).
  assign w_unused_addr = ^req_addr;

  assign w_rword = r_mem[r_addr[IDX_W+1:2]];

  dmem_lane_align u_lane_align (
    .i_offset (r_addr[1:0]),
    .i_size   (r_size),
    .i_wdata  (r_wdata),
    .i_rword  (w_rword),
    .o_be     (w_be),
    .o_wdata  (w_wdata_lanes),
    .o_rdata  (w_rdata_rj)
  );

`ifdef DMEM_MISALIGN_ERR_EN
  always_comb begin
    w_misaligned = 1'b0;
    case (r_size)
      SIZE_BYTE: w_misaligned = 1'b0;
      SIZE_HALF: w_misaligned = r_addr[0];
      default:   w_misaligned = |r_addr[1:0];
    endcase
  end
`else
  assign w_misaligned = 1'b0;
`endif

  // Gated by rst so ready stays low while reset is held, though state is IDLE.
  assign req_ready = rst && (r_state == StIdle);
  assign rsp_valid = (r_state == StResp);
  assign rsp_rdata = DATA_W'(r_rdata);
  assign rsp_err   = r_err;

  always_comb begin
    w_state_next = r_state;
    w_cnt_next   = r_cnt;
    w_rdata_next = r_rdata;
    w_err_next   = r_err;
    w_accept     = 1'b0;
    w_commit     = 1'b0;
    unique case (r_state)
      StIdle: begin
        if (req_valid && req_ready) begin
          w_accept     = 1'b1;
          w_cnt_next   = CNT_LOAD;
          w_state_next = StWait;
        end
      end
      StWait: begin
        if (r_cnt == '0) begin
          w_commit     = 1'b1;
          w_state_next = StResp;
          w_err_next   = w_misaligned;
          w_rdata_next = (r_we || w_misaligned) ? 32'h0 : w_rdata_rj;
        end else begin
          w_cnt_next = r_cnt - 1'b1;
        end
      end
      StResp: begin
        if (rsp_ready) begin
          w_state_next = StIdle;
        end
      end
      default: w_state_next = StIdle;
    endcase
  end

  assign w_mem_we = w_commit && r_we && !w_misaligned;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_state <= StIdle;
      r_cnt   <= '0;
      r_rdata <= '0;
      r_err   <= 1'b0;
      r_addr  <= '0;
      r_we    <= 1'b0;
      r_size  <= SIZE_BYTE;
      r_wdata <= '0;
    end else begin
      r_state <= w_state_next;
      r_cnt   <= w_cnt_next;
      r_rdata <= w_rdata_next;
      r_err   <= w_err_next;
      if (w_accept) begin
        r_addr  <= req_addr[IDX_W+1:0];
        r_we    <= req_we;
        r_size  <= req_size;
        r_wdata <= 32'(req_wdata);
      end
    end
  end

  // Storage is not reset; a reset before commit leaves r_state out of WAIT, so no write.
  always_ff @(posedge clk) begin
    if (w_mem_we) begin
      for (int i = 0; i < 4; i++) begin
        if (w_be[i]) begin
          r_mem[r_addr[IDX_W+1:2]][8*i +: 8] <= w_wdata_lanes[8*i +: 8];
        end
      end
    end
  end

endmodule

// File: tb/tb_dmem_responder.sv
module tb_dmem_responder;
  import dmem_pkg::*;

  localparam int unsigned WAIT_CYC = 3;

  logic        clk       = 1'b0;
  logic        rst       = 1'b0;
  logic        req_valid = 1'b0;
  logic        req_we    = 1'b0;
  logic [1:0]  req_size  = 2'b00;
  logic [31:0] req_addr  = 32'h0;
  logic [31:0] req_wdata = 32'h0;
  logic        rsp_ready = 1'b0;
  logic        req_ready;
  logic        rsp_valid;
  logic [31:0] rsp_rdata;
  logic        rsp_err;

  int n_checks = 0;
  int n_fail   = 0;

  always #5 clk = ~clk;

  dmem_responder #(
    .ADDR_W      (32),
    .DATA_W      (32),
    .DEPTH_WORDS (1024),
    .WAIT_CYCLES (WAIT_CYC)
  ) dut (
    .clk       (clk),
    .rst       (rst),
    .req_valid (req_valid),
    .req_ready (req_ready),
    .req_addr  (req_addr),
    .req_we    (req_we),
    .req_size  (req_size),
    .req_wdata (req_wdata),
    .rsp_valid (rsp_valid),
    .rsp_ready (rsp_ready),
    .rsp_rdata (rsp_rdata),
    .rsp_err   (rsp_err)
  );

  typedef struct {
    logic        we;
    logic [1:0]  sz;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic [31:0] exp_rd;
    logic        exp_err;
  } vec_t;

  vec_t vecs [16];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // One full transaction: accept, measure latency, check payload, handshake.
  task automatic run_txn(input string name, input logic we, input logic [1:0] sz,
                         input logic [31:0] a, input logic [31:0] wd,
                         input logic [31:0] exp_rd, input logic exp_err);
    int lat;
    logic got;
    chk({name, " req_ready"}, 32'(req_ready), 32'd1);
    req_valid = 1'b1;
    req_we    = we;
    req_size  = sz;
    req_addr  = a;
    req_wdata = wd;
    step();
    req_valid = 1'b0;
    req_wdata = ~wd;  // must not matter after the accept edge
    req_addr  = ~a;
    lat = 0;
    got = 1'b0;
    while (!got && lat < 20) begin
      step();
      lat++;
      got = rsp_valid;
    end
    chk({name, " latency"}, 32'(lat), 32'(WAIT_CYC));
    chk({name, " rdata"}, rsp_rdata, exp_rd);
    chk({name, " err"}, 32'(rsp_err), 32'(exp_err));
    rsp_ready = 1'b1;
    step();
    rsp_ready = 1'b0;
    chk({name, " rsp_valid drop"}, 32'(rsp_valid), 32'd0);
  endtask

  initial begin
    logic [31:0] exp_100;
    logic [31:0] held;
    int lat;

    // Reset values while rst is held low.
    #2;
    chk("rst req_ready", 32'(req_ready), 32'd0);
    chk("rst rsp_valid", 32'(rsp_valid), 32'd0);
    chk("rst rsp_rdata", rsp_rdata, 32'd0);
    chk("rst rsp_err", 32'(rsp_err), 32'd0);
    step();
    step();
    rst = 1'b1;
    #1;
    chk("post-rst req_ready", 32'(req_ready), 32'd1);
    step();

    // Known pre-test value, then a store aborted by reset mid-WAIT.
    run_txn("preload", 1'b1, SIZE_WORD, 32'h100, 32'h11223344, 32'h0, 1'b0);
    req_valid = 1'b1;
    req_we    = 1'b1;
    req_size  = SIZE_WORD;
    req_addr  = 32'h100;
    req_wdata = 32'hDEADBEEF;
    step();
    req_valid = 1'b0;
    step();
    rst = 1'b0;
    #1;
    chk("abort rsp_valid", 32'(rsp_valid), 32'd0);
    chk("abort req_ready", 32'(req_ready), 32'd0);
    step();
    rst = 1'b1;
    step();
    run_txn("abort readback", 1'b0, SIZE_WORD, 32'h100, 32'h0, 32'h11223344, 1'b0);

    vecs[0]  = '{1'b1, SIZE_WORD, 32'h100,  32'hDEADBEEF, 32'h0,        1'b0};
    vecs[1]  = '{1'b0, SIZE_WORD, 32'h100,  32'h0,        32'hDEADBEEF, 1'b0};
    vecs[2]  = '{1'b1, SIZE_BYTE, 32'h101,  32'h000000AA, 32'h0,        1'b0};
    vecs[3]  = '{1'b0, SIZE_BYTE, 32'h101,  32'h0,        32'h000000AA, 1'b0};
    vecs[4]  = '{1'b0, SIZE_WORD, 32'h100,  32'h0,        32'hDEADAAEF, 1'b0};
    vecs[5]  = '{1'b0, SIZE_HALF, 32'h102,  32'h0,        32'h0000DEAD, 1'b0};
    vecs[6]  = '{1'b1, SIZE_WORD, 32'h000,  32'hCAFEF00D, 32'h0,        1'b0};
    vecs[7]  = '{1'b0, SIZE_WORD, 32'h1000, 32'h0,        32'hCAFEF00D, 1'b0};
    vecs[8]  = '{1'b0, SIZE_HALF, 32'h100,  32'h0,        32'h0000AAEF, 1'b0};
    vecs[9]  = '{1'b0, SIZE_BYTE, 32'h103,  32'h0,        32'h000000DE, 1'b0};
    vecs[10] = '{1'b1, SIZE_WORD, 32'h104,  32'h0,        32'h0,        1'b0};
    vecs[11] = '{1'b1, SIZE_HALF, 32'h106,  32'h5A5A1234, 32'h0,        1'b0};
    vecs[12] = '{1'b0, SIZE_WORD, 32'h104,  32'h0,        32'h12340000, 1'b0};
    vecs[13] = '{1'b0, SIZE_RSVD, 32'h100,  32'h0,        32'hDEADAAEF, 1'b0};
`ifdef DMEM_MISALIGN_ERR_EN
    vecs[14] = '{1'b1, SIZE_WORD, 32'h102,  32'h12345678, 32'h0,        1'b1};
    exp_100  = 32'hDEADAAEF;
`else
    vecs[14] = '{1'b1, SIZE_WORD, 32'h102,  32'h12345678, 32'h0,        1'b0};
    exp_100  = 32'h12345678;
`endif
    vecs[15] = '{1'b0, SIZE_WORD, 32'h100,  32'h0,        exp_100,      1'b0};

    for (int i = 0; i < 16; i++) begin
      run_txn($sformatf("vec%0d", i), vecs[i].we, vecs[i].sz, vecs[i].addr, vecs[i].wdata,
              vecs[i].exp_rd, vecs[i].exp_err);
    end

    // Backpressure: response held for 5 cycles while stray store requests are offered.
    req_valid = 1'b1;
    req_we    = 1'b0;
    req_size  = SIZE_WORD;
    req_addr  = 32'h100;
    step();
    req_valid = 1'b0;
    lat = 0;
    while (!rsp_valid && lat < 20) begin
      step();
      lat++;
    end
    chk("bp latency", 32'(lat), 32'(WAIT_CYC));
    held = rsp_rdata;
    chk("bp rdata", held, exp_100);
    for (int i = 0; i < 5; i++) begin
      req_valid = (i % 2 == 0);
      req_we    = 1'b1;
      req_addr  = 32'h0;
      req_wdata = 32'h0;
      step();
      chk($sformatf("bp%0d rsp_valid", i), 32'(rsp_valid), 32'd1);
      chk($sformatf("bp%0d rdata", i), rsp_rdata, held);
      chk($sformatf("bp%0d req_ready", i), 32'(req_ready), 32'd0);
    end
    req_valid = 1'b0;
    rsp_ready = 1'b1;
    step();
    rsp_ready = 1'b0;
    chk("bp drop", 32'(rsp_valid), 32'd0);
    for (int i = 0; i < 4; i++) begin
      step();
      chk($sformatf("bp idle%0d rsp_valid", i), 32'(rsp_valid), 32'd0);
    end
    run_txn("bp ignored store", 1'b0, SIZE_WORD, 32'h0, 32'h0, 32'hCAFEF00D, 1'b0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
